// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_loader: byte-stream program loader and instruction ROM for stackCPU |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module program_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int PC_WIDTH    = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   reload,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic                   cpu_reset,
    output logic                   loaded,
    output logic [PC_WIDTH:0]      count,
    output logic                   fault
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HW-1:0]       HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] LAST_ADDR = PC_WIDTH'(MEM_DEPTH - 1);
    localparam logic [PC_WIDTH:0]   DEPTH_W   = (PC_WIDTH + 1)'(MEM_DEPTH);

    localparam logic [2:0] LOAD_HI = 3'd0;
    localparam logic [2:0] LOAD_LO = 3'd1;
    localparam logic [2:0] HOLD    = 3'd2;
    localparam logic [2:0] RUN     = 3'd3;
    localparam logic [2:0] FAULT   = 3'd4;

    logic [2:0]          state_q,   state_d;
    logic [PC_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [PC_WIDTH:0]   count_q,   count_d;
    logic [7:0]          hi_byte_q, hi_byte_d;
    logic [HW-1:0]       hold_q,    hold_d;
    logic                w_we;
    logic                w_accept;

    logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];

    // State register; memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= LOAD_HI;
            wr_addr_q <= '0;
            count_q   <= '0;
            hi_byte_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            hi_byte_q <= hi_byte_d;
            hold_q    <= hold_d;
        end
    end

    assign w_accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        hi_byte_d = hi_byte_q;
        hold_d    = hold_q;
        w_we      = 1'b0;
        case (state_q)
            LOAD_HI: begin
                if (w_accept) begin
                    if (in_last) begin
                        state_d = FAULT;
                    end else begin
                        hi_byte_d = in_data;
                        state_d   = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (w_accept) begin
                    w_we      = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    if (in_last) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                    end else if (wr_addr_q == LAST_ADDR) begin
                        state_d = FAULT;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            RUN, FAULT: begin
                if (reload) begin
                    state_d   = LOAD_HI;
                    count_d   = '0;
                    wr_addr_d = '0;
                end
            end
            default: state_d = LOAD_HI;
        endcase
    end

    always_comb begin
        in_ready  = reset && (state_q == LOAD_HI || state_q == LOAD_LO);
        cpu_reset = (state_q != RUN);
        loaded    = (state_q == RUN);
        fault     = (state_q == FAULT);
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[wr_addr_q[AW-1:0]] <= {hi_byte_q, in_data};
        end
    end

    // Out-of-range pc reads zero instead of indexing past the array
    assign instruction = ({1'b0, pc} < DEPTH_W) ? mem[pc[AW-1:0]] : '0;
    assign instr_valid = loaded && ({1'b0, pc} < count_q);
    assign count       = count_q;

endmodule
`default_nettype wire
